// File: rtl/lift_pkg.sv
// Shared lift definitions: request codes, directions, FSM states.
// Imported by the lift controller FSM and the request queue.
package lift_pkg;

   localparam int CODE_BITS = 3;

   localparam logic [CODE_BITS-1:0] _NONE = 3'b000;
   localparam logic [CODE_BITS-1:0] _1U   = 3'b001;
   localparam logic [CODE_BITS-1:0] _2U   = 3'b010;
   localparam logic [CODE_BITS-1:0] _3U   = 3'b011;
   localparam logic [CODE_BITS-1:0] _4D   = 3'b100;
   localparam logic [CODE_BITS-1:0] _2D   = 3'b110;
   localparam logic [CODE_BITS-1:0] _3D   = 3'b111;

   typedef enum logic [1:0] {
      STAY = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } dir_t;

   // Floor-resting states and floor-to-floor travel states.
   typedef enum logic [3:0] {
      S1, S2, S3, S4,
      S12, S21, S23, S32, S34, S43
   } state_t;

   function automatic logic is_valid_code(input logic [CODE_BITS-1:0] c);
      return (c != _NONE) && (c != 3'b101);
   endfunction

endpackage

// File: rtl/lift_req_fifo_mem.sv
// Request storage: one write port, one read port and a
// compare-all match vector qualified by per-entry valid bits.
module lift_req_fifo_mem #(
   parameter int DEPTH  = 8,
   parameter int CODE_W = 3,
   parameter int PW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PW-1:0]     wa,
   input  logic [CODE_W-1:0] wd,
   input  logic [PW-1:0]     ra,
   output logic [CODE_W-1:0] rd,
   input  logic [CODE_W-1:0] cmp,
   input  logic [DEPTH-1:0]  vld,
   output logic [DEPTH-1:0]  match
);

   logic [CODE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   assign rd = mem[ra];

   for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
      assign match[i] = vld[i] && (mem[i] == cmp);
   end

endmodule

// File: rtl/lift_req_queue.sv
// FIFO of lift call requests feeding the controller FSM; filters
// invalid and duplicate codes and pops once per done-high episode.
module lift_req_queue
   import lift_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int CODE_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic [CODE_W-1:0]        req_code,
   input  logic                     done,
   output logic [CODE_W-1:0]        dout,
   output logic                     q_empty,
   output logic                     q_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     req_drop,
   output logic                     req_dup
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              pop_lock;
   logic [DEPTH-1:0]  ent_vld;
   logic [DEPTH-1:0]  match;
   logic [DEPTH-1:0]  head_oh;
   logic [CODE_W-1:0] rd_data;
   logic              code_ok;
   logic              dup;
   logic              pop;
   logic              push;

   // Entry i is live when its distance from the head is below count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_vld
      logic [PW-1:0] off;
      assign off        = PW'(i) - rd_ptr;
      assign ent_vld[i] = {1'b0, off} < count;
   end

   lift_req_fifo_mem #(
      .DEPTH  (DEPTH),
      .CODE_W (CODE_W),
      .PW     (PW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .wa    (wr_ptr),
      .wd    (req_code),
      .ra    (rd_ptr),
      .rd    (rd_data),
      .cmp   (req_code),
      .vld   (ent_vld),
      .match (match)
   );

   assign q_empty = (count == '0);
   assign q_full  = (count == CW'(DEPTH));
   assign dout    = q_empty ? '0 : rd_data;

   assign pop     = done && !q_empty && !pop_lock;
   assign head_oh = {{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr;
   assign code_ok = is_valid_code(req_code);
   // The head leaving this cycle no longer counts as a duplicate.
   assign dup     = |(match & ~(pop ? head_oh : '0));
   assign push    = req_valid && code_ok && !dup && !q_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pop_lock <= 1'b0;
         req_drop <= 1'b0;
         req_dup  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count + CW'(push) - CW'(pop);
         pop_lock <= done && (pop_lock || pop);
         req_drop <= req_valid && (!code_ok || (!dup && q_full));
         req_dup  <= req_valid && code_ok && dup;
      end
   end

endmodule

// File: tb/tb_lift_req_queue.sv
// Randomized and directed bench for lift_req_queue against a
// queue-based reference model.
module tb_lift_req_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [2:0]    req_code;
   logic          done;
   logic [2:0]    dout;
   logic          q_empty;
   logic          q_full;
   logic [CW-1:0] count;
   logic          req_drop;
   logic          req_dup;

   int checks   = 0;
   int failures = 0;

   logic [2:0] mq[$];
   bit         m_lock;
   bit         m_drop;
   bit         m_dup;

   always #5 clk = ~clk;

   lift_req_queue #(
      .DEPTH  (DEPTH),
      .CODE_W (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_code  (req_code),
      .done      (done),
      .dout      (dout),
      .q_empty   (q_empty),
      .q_full    (q_full),
      .count     (count),
      .req_drop  (req_drop),
      .req_dup   (req_dup)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic verify();
      chk("count",   int'(count),    mq.size());
      chk("q_empty", int'(q_empty),  int'(mq.size() == 0));
      chk("q_full",  int'(q_full),   int'(mq.size() == DEPTH));
      chk("dout",    int'(dout),     mq.size() > 0 ? int'(mq[0]) : 0);
      chk("drop",    int'(req_drop), int'(m_drop));
      chk("dup",     int'(req_dup),  int'(m_dup));
   endtask

   task automatic step(input bit r, input bit v, input logic [2:0] c, input bit d);
      bit ok;
      bit pop;
      bit dp;
      bit full;
      rst       = r;
      req_valid = v;
      req_code  = c;
      done      = d;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_lock = 0;
         m_drop = 0;
         m_dup  = 0;
      end else begin
         ok   = (c != 3'd0) && (c != 3'd5);
         full = (mq.size() == DEPTH);
         pop  = d && (mq.size() > 0) && !m_lock;
         dp   = 0;
         foreach (mq[i])
            if (mq[i] == c && !(pop && i == 0)) dp = 1;
         m_drop = v && (!ok || (!dp && full));
         m_dup  = v && ok && dp;
         if (pop) void'(mq.pop_front());
         if (v && ok && !dp && !full) mq.push_back(c);
         m_lock = d && (m_lock || pop);
      end
      #1;
      verify();
   endtask

   initial begin
      bit d;
      bit v;
      logic [2:0] c;

      step(1, 0, 0, 0);
      step(1, 1, 3'b010, 1);

      // basic pushes
      step(0, 1, 3'b010, 0);
      step(0, 1, 3'b111, 0);
      step(0, 1, 3'b100, 0);
      step(0, 0, 0, 0);

      // one pop per done-high interval
      repeat (4) step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      // duplicates and invalid codes
      step(0, 1, 3'b011, 0);
      step(0, 1, 3'b011, 0);
      step(0, 1, 3'b101, 0);
      step(0, 1, 3'b000, 0);

      // fill, then push while full with a simultaneous pop
      step(0, 1, 3'b001, 0);
      step(0, 1, 3'b110, 0);
      step(0, 1, 3'b010, 1);
      step(0, 0, 0, 0);
      step(0, 1, 3'b010, 0);
      step(0, 1, 3'b111, 1);
      step(0, 0, 0, 0);

      // re-request of the head while it is popped
      step(0, 1, mq[0], 1);
      step(0, 0, 0, 0);

      // drain, then a late request inside one done-high interval
      repeat (DEPTH + 1) begin
         step(0, 0, 0, 1);
         step(0, 0, 0, 0);
      end
      step(0, 0, 0, 1);
      step(0, 1, 3'b001, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      // reset mid-pop
      step(0, 1, 3'b010, 0);
      step(0, 1, 3'b011, 0);
      step(0, 1, 3'b100, 0);
      step(1, 0, 0, 1);
      step(0, 1, 3'b110, 0);
      step(0, 0, 0, 0);

      d = 0;
      repeat (600) begin
         if ($urandom_range(3) == 0) d = !d;
         v = ($urandom_range(1) == 1);
         c = 3'($urandom_range(7));
         step(($urandom_range(99) == 0), v, c, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
